park_gate_ctrl: RTL and testbench
=================================

# park_gate_ctrl

Single-lane barrier controller for the parking system. It arbitrates between entry and exit requests that share one physical gate and sequences the gate through open, pass and close phases. It also owns the occupancy counter (0..CAPACITY) that feeds the floor/full-indication FSM downstream. Entry is refused while the lot is full and exit is ignored while it is empty.

## Interface
Parameters:
- CAPACITY, 12, maximum occupancy; count saturates here by admission control.
- CNT_W, 4, width of count; must hold CAPACITY.
- OPEN_CYCLES, 8, cycles spent in each of the opening and closing phases (≥1).
- PASS_TIMEOUT, 64, maximum cycles in WAIT_PASS before abort (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- entry_req  in  1  level; car waiting at entry loop.
- exit_req  in  1  level; car waiting at exit loop.
- car_passed  in  1  single-cycle pulse from lane sensor.
- entry_grant  out  1  high while an entry transaction owns the gate.
- exit_grant  out  1  high while an exit transaction owns the gate.
- gate_open  out  1  barrier drive; high in OPENING and WAIT_PASS.
- count  out  CNT_W  registered occupancy.
- full  out  1  count == CAPACITY (decoded from the count register).
- timeout_err  out  1  single-cycle pulse when a transaction aborts.

## Operation
- States: IDLE, OPENING, WAIT_PASS, CLOSING. A phase timer is cleared on every state change.
- Eligibility in IDLE:
  - entry_ok = entry_req && count < CAPACITY.
  - exit_ok = exit_req && count > 0.
- IDLE transitions:
  - Only one eligible request: grant it and go to OPENING.
  - Both eligible: round-robin pointer `last` decides. The side not served last wins. `last` is updated at every grant.
  - Neither eligible: stay in IDLE. A full lot with entry_req only stays in IDLE; an empty lot with exit_req only stays in IDLE.
- Grant signals: the chosen grant rises on entering OPENING and stays high until CLOSING exits to IDLE. At most one grant is high at any time.
- OPENING: lasts exactly OPEN_CYCLES cycles, then goes to WAIT_PASS.
- WAIT_PASS:
  - car_passed sampled: count += 1 for entry or −1 for exit, then go to CLOSING.
  - Timer reaches PASS_TIMEOUT with no car_passed: pulse timeout_err for one cycle, leave count unchanged, go to CLOSING.
  - car_passed and timeout in the same cycle: car_passed wins and no error is raised.
- CLOSING: gate_open is low. Lasts exactly OPEN_CYCLES cycles, then goes to IDLE with both grants low.
- car_passed is ignored outside WAIT_PASS.
- Request levels are ignored outside IDLE. Dropping a request mid-transaction does not abort it.
- The count never wraps. Admission rules guarantee 0 ≤ count ≤ CAPACITY.

## Timing
- Reset values:
  - state = IDLE, count = 0, `last` = exit (so entry wins the first tie).
  - entry_grant, exit_grant, gate_open, full, timeout_err = 0.
- rst asserted in any state returns to reset values on the next edge, including mid-transaction. No count update occurs for an in-flight car.
- A request sampled in IDLE at edge t gives grant = 1 and gate_open = 1 from t+1.
- WAIT_PASS is entered at t+1+OPEN_CYCLES.
- car_passed sampled at edge p: count and full update at p+1. CLOSING begins at p+1 and gate_open falls at p+1.
- The grant falls at p+1+OPEN_CYCLES. The earliest next grant is at edge p+1+OPEN_CYCLES, back-to-back with no idle bubble.
- timeout_err is high in the single cycle in which CLOSING is entered by timeout.
- All outputs are registered or decoded from registers. There is no combinational path from any input to any output.

## Test plan
- Reset, then entry_req = 1 alone: entry_grant rises 1 cycle later. gate_open is high for OPEN_CYCLES+wait cycles. Pulse car_passed: count goes 0→1 and the grant drops OPEN_CYCLES cycles after the pulse.
- Fill to 12 by repeated entries: full = 1. A further entry_req is never granted. exit_req with car_passed gives count 11 and full = 0.
- From count = 5, hold entry_req and exit_req continuously with car_passed each time: grants alternate entry, exit, entry… starting with the side opposite `last`. Count oscillates 5↔6.
- Empty lot with exit_req = 1: no grant and count stays 0. Entry with no car_passed: timeout_err pulses exactly PASS_TIMEOUT cycles after WAIT_PASS entry and count stays 0.
- Assert rst during WAIT_PASS with count = 3: next cycle count = 0, grants = 0, gate_open = 0. A car_passed pulse in the same cycle as rst has no effect.
- car_passed pulses during OPENING and CLOSING are ignored, with count unchanged. car_passed coincident with the timeout cycle updates count and raises no timeout_err.

Source files
------------

// File: rtl/park_gate_ctrl.sv
// park_gate_ctrl: single-lane barrier arbiter, gate sequencer and occupancy counter
module park_gate_ctrl #(
  parameter int CAPACITY     = 12,
  parameter int CNT_W        = 4,
  parameter int OPEN_CYCLES  = 8,
  parameter int PASS_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             timeout_err
);
  localparam int TMAX = PASS_TIMEOUT > OPEN_CYCLES ? PASS_TIMEOUT : OPEN_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic last;
  logic entry_ok, exit_ok, pick_entry, pick_any, phase_done, arb, launch, to;
  assign entry_ok   = entry_req && count < CNT_W'(CAPACITY);
  assign exit_ok    = exit_req && count != '0;
  assign pick_any   = entry_ok || exit_ok;
  assign pick_entry = entry_ok && (!exit_ok || last);
  assign phase_done = timer == TW'(OPEN_CYCLES - 1);
  assign arb        = state == IDLE || (state == CLOSING && phase_done);
  assign launch     = arb && pick_any;
  assign gate_open  = state == OPENING || state == WAIT_PASS;
  assign full       = count == CNT_W'(CAPACITY);
  // next state; closing hands straight over to a waiting request so there is no idle bubble
  always_comb begin
    state_n = state;
    to = 1'b0;
    unique case (state)
      IDLE:      state_n = pick_any ? OPENING : IDLE;
      OPENING:   state_n = phase_done ? WAIT_PASS : OPENING;
      WAIT_PASS: begin
        to = !car_passed && timer == TW'(PASS_TIMEOUT - 1);
        state_n = (car_passed || to) ? CLOSING : WAIT_PASS;
      end
      CLOSING:   state_n = phase_done ? (pick_any ? OPENING : IDLE) : CLOSING;
    endcase
  end
  // state, phase timer, grants, round-robin pointer and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      count <= '0;
      last <= 1'b1;
      entry_grant <= 1'b0;
      exit_grant <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (state_n != state || state == IDLE) ? '0 : timer + TW'(1);
      timeout_err <= to;
      if (state == WAIT_PASS && car_passed)
        count <= entry_grant ? count + CNT_W'(1) : count - CNT_W'(1);
      if (arb) begin
        entry_grant <= launch && pick_entry;
        exit_grant <= launch && !pick_entry;
      end
      if (launch) last <= !pick_entry;
    end
  end
endmodule

// File: tb/tb_park_gate_ctrl.sv
// tb_park_gate_ctrl: randomized phases checked against a transaction-timeline model
module tb_park_gate_ctrl;
  localparam int CAP = 12, OC = 8, PT = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic entry_req = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
  logic entry_grant, exit_grant, gate_open, full, timeout_err;
  logic [3:0] count;
  int passed = 0, total = 0;
  int cyc = 0;
  int own = 0, g = 0, c = -1, cnt = 0, terr = 0;
  bit last_exit = 1'b1;
  park_gate_ctrl #(.CAPACITY(CAP), .CNT_W(4), .OPEN_CYCLES(OC), .PASS_TIMEOUT(PT)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .gate_open(gate_open),
    .count(count), .full(full), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total += 1;
    assert (obs === exp) passed += 1;
    else $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
  endtask
  // own: 0 none, 1 entry, 2 exit; g: edge of grant; c: edge CLOSING began (-1 = not yet)
  task automatic model(input bit e, input bit x, input bit cp, input bit r, input int n);
    bit eok, xok;
    if (r) begin
      own = 0; c = -1; cnt = 0; last_exit = 1'b1; terr = 0;
    end else begin
      terr = 0;
      if (own != 0 && c < 0 && n >= g + OC + 1) begin
        if (cp) begin cnt += (own == 1) ? 1 : -1; c = n; end
        else if (n == g + OC + PT) begin c = n; terr = 1; end
      end
      if (own == 0 || (c >= 0 && n == c + OC)) begin
        eok = e && cnt < CAP;
        xok = x && cnt > 0;
        own = 0;
        if (eok || xok) begin
          own = (eok && (!xok || last_exit)) ? 1 : 2;
          last_exit = (own == 2);
          g = n;
          c = -1;
        end
      end
    end
  endtask
  task automatic step(input bit e, input bit x, input bit cp, input bit r);
    @(negedge clk);
    entry_req = e; exit_req = x; car_passed = cp; rst = r;
    @(posedge clk);
    model(e, x, cp, r, cyc);
    cyc += 1;
    #1;
    chk("entry_grant", int'(entry_grant), int'(own == 1));
    chk("exit_grant", int'(exit_grant), int'(own == 2));
    chk("gate_open", int'(gate_open), int'(own != 0 && c < 0));
    chk("count", int'(count), cnt);
    chk("full", int'(full), int'(cnt == CAP));
    chk("timeout_err", int'(timeout_err), terr);
  endtask
  task automatic phase(input int pe, input int px, input int pc, input int pr, input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < pe, $urandom_range(99) < px,
           $urandom_range(99) < pc, $urandom_range(999) < pr);
  endtask
  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    phase(0, 90, 40, 0, 60);
    phase(90, 0, 30, 0, 600);
    phase(60, 0, 50, 0, 200);
    phase(0, 50, 30, 0, 600);
    phase(0, 90, 40, 0, 100);
    phase(80, 80, 20, 0, 800);
    phase(80, 20, 0, 0, 300);
    phase(70, 70, 2, 0, 800);
    phase(60, 60, 15, 10, 800);
    phase(0, 0, 0, 0, 20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
